// File: rtl/tgen_rx_lin.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tgen_rx_lin : nibble-bus word receiver with output FIFO and event flags
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tgen_rx_lin #(
   parameter int NIBBLES    = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_i,
   input  logic                   clr_i,
   input  logic [3:0]             pad_data_i,
   input  logic                   pad_wrd_i,
   output logic [4*NIBBLES-1:0]   data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [CNT_WIDTH-1:0]   word_cnt_o,
   output logic                   overflow_o,
   output logic                   frame_err_o,
   output logic                   busy_o,
   output logic [1:0]             events_o
);

   localparam int W   = 4 * NIBBLES;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int NCW = $clog2(NIBBLES) + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [W-1:0]          sr_q, sr_d;
   logic [NCW-1:0]        nib_cnt_q, nib_cnt_d;
   logic [W-1:0]          mem_q [FIFO_DEPTH];
   logic [W-1:0]          mem_d [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic                  overflow_q, overflow_d;
   logic                  frame_err_q, frame_err_d;
   logic [1:0]            events_q, events_d;

   logic [W-1:0]          shifted;
   logic                  push, ferr_evt, pop, full, accept, reject;

   assign shifted = {sr_q[W-5:0], pad_data_i};
   assign pop     = (count_q != '0) && ready_i;
   assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
   assign accept  = push && (!full || pop);
   assign reject  = push && !accept;

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      nib_cnt_d   = nib_cnt_q;
      push        = 1'b0;
      ferr_evt    = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_i && pad_wrd_i) begin
               sr_d      = shifted;
               nib_cnt_d = NCW'(1);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (!en_i) begin
               state_d   = IDLE;
               nib_cnt_d = '0;
            end else if (pad_wrd_i) begin
               // strobe mid-word: restart the word on this nibble
               sr_d      = shifted;
               nib_cnt_d = NCW'(1);
               ferr_evt  = 1'b1;
            end else begin
               sr_d      = shifted;
               nib_cnt_d = nib_cnt_q + NCW'(1);
               if (nib_cnt_q == NCW'(NIBBLES - 1)) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      word_cnt_d  = word_cnt_q;
      overflow_d  = overflow_q | reject;
      frame_err_d = frame_err_q | ferr_evt;
      events_d    = {reject | ferr_evt, accept};

      if (accept) begin
         mem_d[wr_ptr_q] = shifted;
         wr_ptr_d        = wr_ptr_q + AW'(1);
         word_cnt_d      = word_cnt_q + CNT_WIDTH'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + AW'(1);
      case ({accept, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      // clear wins over every push, pop and flag update of this cycle
      if (clr_i) begin
         state_d     = IDLE;
         nib_cnt_d   = '0;
         mem_d       = mem_q;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         word_cnt_d  = '0;
         overflow_d  = 1'b0;
         frame_err_d = 1'b0;
         events_d    = 2'b00;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         nib_cnt_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         word_cnt_q  <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         events_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         nib_cnt_q   <= nib_cnt_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         word_cnt_q  <= word_cnt_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
         events_q    <= events_d;
      end
   end

   assign data_o      = mem_q[rd_ptr_q];
   assign valid_o     = (count_q != '0);
   assign word_cnt_o  = word_cnt_q;
   assign overflow_o  = overflow_q;
   assign frame_err_o = frame_err_q;
   assign busy_o      = (state_q == SHIFT);
   assign events_o    = events_q;

endmodule
`default_nettype wire

// File: tb/tb_tgen_rx_lin.sv
`default_nettype none
// tb_tgen_rx_lin : directed and randomized checks against a queue-based word model
module tb_tgen_rx_lin;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0, clr = 1'b0, wrd = 1'b0, ready = 1'b0;
   logic [3:0]    pad = 4'h0;
   wire  [31:0]   data_o;
   wire           valid_o, overflow_o, frame_err_o, busy_o;
   wire  [CW-1:0] word_cnt_o;
   wire  [1:0]    events_o;

   int errors = 0;
   int checks = 0;
   int ev1_cnt = 0;

   tgen_rx_lin #(.NIBBLES(8), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
      .pad_data_i(pad), .pad_wrd_i(wrd),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
      .word_cnt_o(word_cnt_o), .overflow_o(overflow_o), .frame_err_o(frame_err_o),
      .busy_o(busy_o), .events_o(events_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: words as nibble lists, FIFO as a queue
   bit [3:0]    m_nibs[$];
   bit [31:0]   m_fifo[$];
   bit          m_in_word, m_ovf, m_ferr;
   bit [CW-1:0] m_cnt;
   bit [1:0]    m_ev;

   task automatic model_reset();
      m_nibs.delete(); m_fifo.delete();
      m_in_word = 0; m_ovf = 0; m_ferr = 0; m_cnt = '0; m_ev = 2'b00;
   endtask

   initial model_reset();

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else if (clr) begin
         model_reset();
      end else begin
         bit popped, completed, taken, err;
         bit [31:0] w;
         popped = (m_fifo.size() > 0) && ready;
         completed = 0; err = 0; w = 0;
         if (!m_in_word) begin
            if (en && wrd) begin m_nibs = {pad}; m_in_word = 1; end
         end else if (!en) begin
            m_in_word = 0;
         end else if (wrd) begin
            err = 1; m_ferr = 1; m_nibs = {pad};
         end else begin
            m_nibs.push_back(pad);
            if (m_nibs.size() == 8) begin
               foreach (m_nibs[i]) w = (w << 4) | 32'(m_nibs[i]);
               completed = 1; m_in_word = 0;
            end
         end
         taken = completed && (m_fifo.size() < 4 || popped);
         if (popped) void'(m_fifo.pop_front());
         if (taken) begin m_fifo.push_back(w); m_cnt = m_cnt + 1'b1; end
         else if (completed) begin m_ovf = 1; err = 1; end
         m_ev = {err, taken};
      end
   end

   // ---------------- per-cycle compare
   always @(posedge clk) begin
      #2;
      if (!rst) begin
         chk("valid", valid_o, m_fifo.size() > 0);
         if (m_fifo.size() > 0) chk("data", data_o, m_fifo[0]);
         chk("word_cnt", word_cnt_o, m_cnt);
         chk("overflow", overflow_o, m_ovf);
         chk("frame_err", frame_err_o, m_ferr);
         chk("busy", busy_o, m_in_word);
         chk("events", events_o, m_ev);
      end
   end

   always @(posedge clk) begin
      #1;
      if (events_o[1]) ev1_cnt++;
   end

   // ---------------- stimulus helpers (inputs change on the falling edge)
   task automatic drive(input logic e, input logic s, input logic [3:0] d,
                        input logic r, input logic c);
      @(negedge clk);
      en = e; wrd = s; pad = d; ready = r; clr = c;
   endtask

   task automatic send_word(input logic [31:0] w, input logic r, input logic r_last);
      for (int i = 0; i < 8; i++)
         drive(1'b1, i == 0, w[31-4*i -: 4], (i == 7) ? r_last : r, 1'b0);
   endtask

   task automatic idle(input int n, input logic r);
      repeat (n) drive(1'b0, 1'b0, 4'h0, r, 1'b0);
   endtask

   task automatic do_clr();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, valid_o, 0);
      chk({tag, "_data"}, data_o, 0);
      chk({tag, "_cnt"}, word_cnt_o, 0);
      chk({tag, "_ovf"}, overflow_o, 0);
      chk({tag, "_ferr"}, frame_err_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_events"}, events_o, 0);
   endtask

   initial begin
      int popped_n;
      int pos;
      logic s, e, c;
      int r;

      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk) rst = 1'b0;

      // single word
      send_word(32'h12345678, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("single_data", data_o, 32'h12345678);
      chk("single_valid", valid_o, 1);
      chk("single_ev0", events_o, 2'b01);
      chk("single_cnt", word_cnt_o, 1);
      idle(2, 1'b1);

      // back-to-back words
      send_word(32'hDEADBEEF, 1'b1, 1'b1);
      send_word(32'h00000000, 1'b1, 1'b1);
      send_word(32'hFFFFFFFF, 1'b1, 1'b1);
      idle(3, 1'b1);
      chk("b2b_cnt", word_cnt_o, 4);
      chk("b2b_ovf", overflow_o, 0);
      chk("b2b_ferr", frame_err_o, 0);

      // overflow with stalled sink, then drain
      do_clr();
      ev1_cnt = 0;
      for (int i = 0; i < 5; i++) send_word(32'h1000_0000 * (i + 1) + i, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("ovf_flag", overflow_o, 1);
      chk("ovf_cnt", word_cnt_o, 4);
      chk("ovf_ev1_pulses", ev1_cnt, 1);
      popped_n = 0;
      repeat (8) begin
         @(negedge clk);
         if (valid_o) popped_n++;
         en = 0; wrd = 0; ready = 1; clr = 0;
      end
      chk("ovf_drained", popped_n, 4);

      // full FIFO plus a pop on the completing cycle
      do_clr();
      for (int i = 0; i < 4; i++) send_word(32'hA0A0_0000 + i, 1'b0, 1'b0);
      send_word(32'h5555AAAA, 1'b0, 1'b1);
      idle(1, 1'b0);
      chk("fullpop_ovf", overflow_o, 0);
      chk("fullpop_cnt", word_cnt_o, 5);
      idle(6, 1'b1);

      // framing error at nibble 4
      do_clr();
      ev1_cnt = 0;
      drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
      send_word(32'hABCDEF01, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("frame_data", data_o, 32'hABCDEF01);
      chk("frame_cnt", word_cnt_o, 1);
      idle(2, 1'b0);
      chk("frame_flag", frame_err_o, 1);
      chk("frame_ev1_pulses", ev1_cnt, 1);

      // abort via en low
      do_clr();
      drive(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 4'h2, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b0);
      idle(3, 1'b1);
      chk("abort_cnt", word_cnt_o, 0);
      chk("abort_valid", valid_o, 0);
      chk("abort_ovf", overflow_o, 0);
      chk("abort_ferr", frame_err_o, 0);

      // asynchronous reset mid-word
      send_word(32'h11111111, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 4'(i + 7), 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1 chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0; en = 0; wrd = 0;
      send_word(32'hCAFEF00D, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("post_rst_data", data_o, 32'hCAFEF00D);
      chk("post_rst_cnt", word_cnt_o, 1);
      idle(3, 1'b1);

      // randomized traffic, counter wraps many times
      pos = 0;
      for (int n = 0; n < 5000; n++) begin
         r = int'($urandom_range(0, 199));
         e = (r != 0);
         c = (r == 2);
         s = (pos == 0) ? (r < 170) : (r == 1);
         if (!e) pos = 0;
         else if (s) pos = 1;
         else if (pos > 0) pos = (pos == 7) ? 0 : pos + 1;
         drive(e, s, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), c);
      end
      idle(10, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tgen_rx_lin.md
# tgen_rx_lin

Receive-side counterpart of the linear traffic-generator transmitter. It samples a 4-bit nibble bus plus a word-framing strobe from the pads, already synchronised to `clk_i`, and assembles nibbles MSB-first into words. Completed words are buffered in a small FIFO and presented on a valid/ready stream that feeds the UDMA RX channel. It also keeps a received-word counter, sticky error flags and event pulses for the register/interrupt logic.

## Interface
Parameters:
- NIBBLES, 8, nibbles per word; word width W = 4*NIBBLES (must be ≥2)
- FIFO_DEPTH, 4, word entries in output FIFO (power of 2, ≥2)
- CNT_WIDTH, 16, width of received-word counter

Ports:
- Reset is asynchronous and active-high.
- clk_i  in  1  single block clock (pad sampling, FIFO and stream)
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  receive enable (level)
- clr_i  in  1  synchronous clear of FSM, FIFO, counter and sticky flags
- pad_data_i  in  4  nibble bus from pads
- pad_wrd_i  in  1  word strobe; high on the first nibble of every word
- data_o  out  W  FIFO head word
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  downstream accept; pop when valid_o & ready_i
- word_cnt_o  out  CNT_WIDTH  words accepted into FIFO, wraps modulo 2^CNT_WIDTH
- overflow_o  out  1  sticky: completed word dropped because FIFO full
- frame_err_o  out  1  sticky: pad_wrd_i seen mid-word
- busy_o  out  1  FSM in SHIFT
- events_o  out  2  [0] one-cycle pulse per accepted word; [1] one-cycle pulse per new overflow or frame error

## Operation
- FSM states: IDLE, SHIFT. Shift register sr (W bits) and nibble counter nib_cnt (log2(NIBBLES)+1 bits).
- IDLE: if en_i & pad_wrd_i, load sr <= {sr[W-5:0], pad_data_i}, nib_cnt <= 1, go to SHIFT. Otherwise stay; nibbles without a strobe are ignored.
- SHIFT, no strobe: shift the nibble in, nib_cnt++. When this is the NIBBLES-th nibble, form word = {sr[W-5:0], pad_data_i}, attempt a push, and go to IDLE.
- SHIFT with pad_wrd_i = 1 (framing error): discard the partial word. The current nibble becomes nibble 1 of a new word (nib_cnt <= 1, stay in SHIFT). Set frame_err_o and pulse events_o[1].
- After the last nibble the FSM is in IDLE. A strobe on the very next cycle starts the next word, so back-to-back words need no gap.
- Push accept rule: accepted if FIFO count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - On accept: write the word, word_cnt_o++, pulse events_o[0].
  - On reject: drop the word, leave the FIFO untouched, set overflow_o, pulse events_o[1].
- events_o[1] is a single pulse even when both error conditions occur in one cycle.
- en_i low while in SHIFT: go to IDLE next edge and discard the partial word. No flag, no event. FIFO and stream unaffected (draining continues).
- clr_i, highest priority after reset: FSM to IDLE, FIFO emptied, word_cnt_o, overflow_o, frame_err_o, nib_cnt cleared. A push or pop in the same cycle is ignored.
- Priority order: rst_i > clr_i > en_i low > framing error > normal shift.

## Timing
- Reset values: data_o = 0 (storage and pointers reset), valid_o = 0, word_cnt_o = 0, overflow_o = 0, frame_err_o = 0, busy_o = 0, events_o = 0. FSM is in IDLE.
- Sampling: pad_data_i and pad_wrd_i are sampled on every rising clk_i edge; one nibble per cycle.
- Latency: last nibble sampled at edge k, then valid_o, data_o and events_o[0] are visible after edge k (cycle k+1). word_cnt_o updates at the same edge.
- Stream: data_o is fall-through from the FIFO head. data_o must be held stable while valid_o & !ready_i. Pop occurs at the edge where valid_o & ready_i.
- Sustained rate: one word per NIBBLES cycles. With ready_i held high the FIFO never overflows.
- Reset mid-word: partial word lost, all state returns to reset values immediately (asynchronous).
- word_cnt_o wraps from 2^CNT_WIDTH−1 to 0 with no flag.

## Test plan
- Single word: strobe with nibbles 1,2,…,8 on consecutive cycles → data_o = 0x12345678, valid_o high the cycle after the 8th nibble, events_o[0] pulses once, word_cnt_o = 1.
- Back-to-back: 3 words 0xDEADBEEF, 0x00000000, 0xFFFFFFFF with no gaps, ready_i = 1 → 3 words out in order, no flags, word_cnt_o = 3.
- Overflow: ready_i = 0, send 5 words → first 4 stored in order, 5th dropped, overflow_o = 1, events_o[1] pulses once, word_cnt_o = 4. Then raise ready_i → exactly 4 words drain.
- Full plus simultaneous pop: FIFO full, ready_i = 1 on the cycle the 5th word completes → 5th word accepted, overflow_o stays 0.
- Framing error: strobe mid-word at nibble 4, followed by nibbles A,B,C,D,E,F,0,1 (strobe on A) → frame_err_o = 1, one events_o[1] pulse, single output word 0xABCDEF01.
- Abort and reset: drop en_i after nibble 3 → nothing pushed and no flags. Assert rst_i after nibble 5 of the next word → all outputs return to 0 and a following full word is received correctly.
